// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// uart_rx_cfg : configurable UART receiver (width/parity/stop) with valid/ready
//               output; UART_RX_BREAK_DET_EN enables line-break detection.
// Revision    : 1.0
// ============================================================================
module uart_rx_cfg #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy,
  output logic                  break_det
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 2;
  localparam logic [CW-1:0] C_HALF      = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] C_LAST      = CW'(CPB - 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [3:0]    C_DW_LAST   = 4'(DATA_WIDTH - 1);
  localparam logic          C_STOP_LAST = (STOP_BITS == 2);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx_cfg: CLK_FREQ/BAUD_RATE must be at least 4");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_width_check
    $error("uart_rx_cfg: DATA_WIDTH must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_cfg_check
    $error("uart_rx_cfg: illegal PARITY_MODE or STOP_BITS");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_RX_BREAK_DET_EN
    , S_BREAK = 3'd5
`endif
  } state_t;

  logic                  sync_q, rxs_q;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                  zero_q, zero_d;
  logic                  break_q, break_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    done_d       = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    zero_d       = zero_q;
    break_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == C_HALF) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d    = S_DATA;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_d     = 1'b1;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == C_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rxs_q, shreg_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef UART_RX_BREAK_DET_EN
          zero_d    = zero_q & ~rxs_q;
`endif
          if (bit_cnt_q == C_DW_LAST) begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_PARITY: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
          perr_d  = (PARITY_MODE == 2) ? (rxs_q != ~^shreg_q) : (rxs_q != ^shreg_q);
`ifdef UART_RX_BREAK_DET_EN
          zero_d  = zero_q & ~rxs_q;
`endif
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == C_LAST) begin
          cnt_d = '0;
`ifdef UART_RX_BREAK_DET_EN
          // All-zero frame including the first stop bit: a line break, not data
          if (!stop_cnt_q && zero_q && !rxs_q) begin
            state_d = S_BREAK;
            break_d = 1'b1;
          end else
`endif
          begin
            if (!rxs_q) ferr_d = 1'b1;
            if (stop_cnt_q == C_STOP_LAST) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Completion runs one cycle after the last stop sample, against the live handshake
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d == S_START) || (state_d == S_DATA) ||
             (state_d == S_PARITY) || (state_d == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_q       <= 1'b0;
      break_q      <= 1'b0;
`endif
    end else begin
      sync_q       <= rxd;
      rxs_q        <= sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
`ifdef UART_RX_BREAK_DET_EN
      zero_q       <= zero_d;
      break_q      <= break_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = busy_q;
`ifdef UART_RX_BREAK_DET_EN
  assign break_det   = break_q;
`else
  assign break_det   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_cfg : self-checking bench for uart_rx_cfg at default parameters.
// Revision       : 1.0
// ============================================================================
module tb_uart_rx_cfg;

  localparam int CPB = 50_000_000 / 115_200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, busy, break_det;

  uart_rx_cfg dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy),
    .break_det   (break_det)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } word_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  int    ovr_cnt = 0;
  int    brk_cnt = 0;
  word_t got_q[$];
  word_t exp_q[$];

  // Handshakes and single-cycle pulses observed between clock edges
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_data, parity_err, frame_err});
    if (overrun_err) ovr_cnt++;
    if (break_det) brk_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: even parity means the parity bit makes the count of ones even
  function automatic word_t model(input logic [7:0] d, input logic pbit, input logic stop);
    word_t w;
    int    ones;
    ones = $countones(d) + int'(pbit);
    w.d  = d;
    w.p  = (ones % 2) != 0;
    w.f  = (stop == 1'b0);
    return w;
  endfunction

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input int gap);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pbit);
    send_bit(stop);
    for (int i = 0; i < gap; i++) send_bit(1'b1);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  task automatic consume();
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
  endtask

  initial begin
    vec_t  vecs[3];
    word_t w;
    int    ovr_base;

    vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};

    // Reset held for one cycle
    @(negedge clk);
    reset = 1'b0;
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_flags", {28'd0, parity_err, frame_err, overrun_err, break_det}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);

    // 0xA5 with latency window around the stop-bit mid-sample
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'hA5 >> i);
    send_bit(1'b0);
    rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("a5_valid_not_early", {31'd0, rx_valid}, 32'd0);
    repeat (6) @(negedge clk);
    check("a5_valid_on_time", {31'd0, rx_valid}, 32'd1);
    repeat (CPB - CPB / 2 - 6 + CPB) @(negedge clk);
    check("a5_data_held", {24'd0, rx_data}, 32'hA5);
    check("a5_flags", {30'd0, parity_err, frame_err}, 32'd0);
    check("a5_still_valid", {31'd0, rx_valid}, 32'd1);
    consume();
    check("a5_consumed", {31'd0, rx_valid}, 32'd0);

    // Table of single frames, each held until consumed
    for (int k = 0; k < 3; k++) begin
      send_frame(vecs[k].data, vecs[k].pbit, vecs[k].stop, 1);
      check($sformatf("vec%0d_valid", k), {31'd0, rx_valid}, 32'd1);
      check($sformatf("vec%0d_data", k), {24'd0, rx_data}, {24'd0, vecs[k].exp_data});
      check($sformatf("vec%0d_perr", k), {31'd0, parity_err}, {31'd0, vecs[k].exp_perr});
      check($sformatf("vec%0d_ferr", k), {31'd0, frame_err}, {31'd0, vecs[k].exp_ferr});
      consume();
      check($sformatf("vec%0d_consumed", k), {31'd0, rx_valid}, 32'd0);
    end

    // All-zero frame
`ifdef UART_RX_BREAK_DET_EN
    for (int i = 0; i < 11 + 20; i++) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("break_pulses", brk_cnt, 32'd1);
    check("break_no_valid", {31'd0, rx_valid}, 32'd0);
    check("break_busy", {31'd0, busy}, 32'd0);
`else
    send_frame(8'h00, 1'b0, 1'b0, 2);
    check("zero_valid", {31'd0, rx_valid}, 32'd1);
    check("zero_data", {24'd0, rx_data}, 32'd0);
    check("zero_ferr", {31'd0, frame_err}, 32'd1);
    check("zero_perr", {31'd0, parity_err}, 32'd0);
    check("zero_no_break", brk_cnt, 32'd0);
    consume();
`endif

    // Short low glitch on the line
    rxd = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (50) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB / 2 + 3) @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);

    // Back-to-back frames with no consumer: second frame is dropped
    ovr_base = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 1);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_pulses", ovr_cnt - ovr_base, 32'd1);
    consume();
    check("ovr_consumed", {31'd0, rx_valid}, 32'd0);
    set_ready(1'b1);
    got_q.delete();
    send_frame(8'h33, 1'b0, 1'b1, 1);
    check("after_ovr_data", {24'd0, rx_data}, 32'h33);
    check("after_ovr_handshakes", got_q.size(), 32'd1);

    // Randomised frames, consumer always ready
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] d;
      logic       pb, sb;
      d  = 8'($urandom_range(0, 255));
      pb = (^d) ^ ($urandom_range(0, 2) == 0);
      sb = ($urandom_range(0, 2) != 0);
      exp_q.push_back(model(d, pb, sb));
      send_frame(d, pb, sb, 1);
    end
    check("rand_count", got_q.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_q.size()) w = got_q[k];
      else w = '1;
      check($sformatf("rand%0d_word", k), {22'd0, w}, {22'd0, exp_q[k]});
    end

    // Reset in the middle of data bit 3 of 0xF0
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(8'hF0 >> i);
    rxd = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_data", {24'd0, rx_data}, 32'd0);
    check("midrst_flags", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("midrst_idle_valid", {31'd0, rx_valid}, 32'd0);
    got_q.delete();
    send_frame(8'h7E, 1'b0, 1'b1, 1);
    check("7e_handshakes", got_q.size(), 32'd1);
    if (got_q.size() > 0) w = got_q[0];
    else w = '1;
    check("7e_word", {22'd0, w}, {22'd0, model(8'h7E, 1'b0, 1'b1)});
    check("7e_data", {24'd0, rx_data}, 32'h7E);

    check("total_overruns", ovr_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
